// File: rtl/ledpanel_fill_ctrl.sv
// Write-side controller for the 32x32 RGB888 panel: arbitrates host pixel writes against a rectangle-fill engine.
// Optional fill_abort input is compiled in when LEDPANEL_FILL_ABORT_EN is defined.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no fill active; commands accepted, host always granted
// FILL  | fill engine walks the rectangle row-major, one write per grant
module ledpanel_fill_ctrl #(
  parameter int FILL_BURST = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_x0,
  input  logic [4:0]  cmd_y0,
  input  logic [4:0]  cmd_x1,
  input  logic [4:0]  cmd_y1,
  input  logic [23:0] cmd_rgb,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [4:0]  host_x,
  input  logic [4:0]  host_y,
  input  logic [23:0] host_rgb,
`ifdef LEDPANEL_FILL_ABORT_EN
  input  logic        fill_abort,
`endif
  output logic        wr_enable,
  output logic [4:0]  wr_addr_x,
  output logic [4:0]  wr_addr_y,
  output logic [23:0] wr_rgb_data,
  output logic        busy,
  output logic        fill_done
);

  localparam int BW = (FILL_BURST < 1) ? 1 : $clog2(FILL_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(FILL_BURST);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    xmin_q, xmin_d, xmax_q, xmax_d;
  logic [4:0]    ymin_q, ymin_d, ymax_q, ymax_d;
  logic [4:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          host_ready_q, host_ready_d;
  logic          busy_q, busy_d;
  logic          fill_done_q, fill_done_d;
  logic          wr_enable_q, wr_enable_d;
  logic [4:0]    wr_addr_x_q, wr_addr_x_d, wr_addr_y_q, wr_addr_y_d;
  logic [23:0]   wr_rgb_q, wr_rgb_d;

  logic abort_req;
  logic host_gnt;
  logic fill_gnt;
  logic cmd_acc;
  logic last_px;

`ifdef LEDPANEL_FILL_ABORT_EN
  assign abort_req = fill_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Host wins whenever it is ready; the fill engine only gets leftover cycles.
  assign host_gnt = host_valid && host_ready_q;
  assign fill_gnt = (state_q == S_FILL) && !host_gnt && !abort_req;
  assign cmd_acc  = cmd_valid && cmd_ready_q;
  assign last_px  = (cur_x_q == xmax_q) && (cur_y_q == ymax_q);

  always_comb begin
    state_d     = state_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    rgb_d       = rgb_q;
    burst_cnt_d = burst_cnt_q;
    fill_done_d = 1'b0;
    wr_enable_d = 1'b0;
    wr_addr_x_d = wr_addr_x_q;
    wr_addr_y_d = wr_addr_y_q;
    wr_rgb_d    = wr_rgb_q;

    if (host_gnt) begin
      wr_enable_d = 1'b1;
      wr_addr_x_d = host_x;
      wr_addr_y_d = host_y;
      wr_rgb_d    = host_rgb;
      burst_cnt_d = '0;
    end else if (fill_gnt) begin
      wr_enable_d = 1'b1;
      wr_addr_x_d = cur_x_q;
      wr_addr_y_d = cur_y_q;
      wr_rgb_d    = rgb_q;
      if (burst_cnt_q != BURST_MAX) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          state_d     = S_FILL;
          xmin_d      = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
          xmax_d      = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
          ymin_d      = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
          ymax_d      = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
          cur_x_d     = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
          cur_y_d     = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
          rgb_d       = cmd_rgb;
          burst_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (fill_gnt) begin
          if (last_px) begin
            state_d     = S_IDLE;
            fill_done_d = 1'b1;
          end else if (cur_x_q == xmax_q) begin
            cur_x_d = xmin_q;
            cur_y_d = cur_y_q + 5'd1;
          end else begin
            cur_x_d = cur_x_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered from next-state so they depend only on state/burst_cnt.
    cmd_ready_d  = (state_d == S_IDLE);
    host_ready_d = (state_d == S_IDLE) || (burst_cnt_d == BURST_MAX);
    busy_d       = (state_d == S_FILL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      rgb_q        <= '0;
      burst_cnt_q  <= '0;
      cmd_ready_q  <= 1'b0;
      host_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      fill_done_q  <= 1'b0;
      wr_enable_q  <= 1'b0;
      wr_addr_x_q  <= '0;
      wr_addr_y_q  <= '0;
      wr_rgb_q     <= '0;
    end else begin
      state_q      <= state_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      rgb_q        <= rgb_d;
      burst_cnt_q  <= burst_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      host_ready_q <= host_ready_d;
      busy_q       <= busy_d;
      fill_done_q  <= fill_done_d;
      wr_enable_q  <= wr_enable_d;
      wr_addr_x_q  <= wr_addr_x_d;
      wr_addr_y_q  <= wr_addr_y_d;
      wr_rgb_q     <= wr_rgb_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign host_ready  = host_ready_q;
  assign busy        = busy_q;
  assign fill_done   = fill_done_q;
  assign wr_enable   = wr_enable_q;
  assign wr_addr_x   = wr_addr_x_q;
  assign wr_addr_y   = wr_addr_y_q;
  assign wr_rgb_data = wr_rgb_q;

endmodule

// File: tb/tb_ledpanel_fill_ctrl.sv
// Bench for ledpanel_fill_ctrl: pixel-list reference model, directed cases plus randomized traffic.
// Abort cases are compiled in when LEDPANEL_FILL_ABORT_EN is defined.
module tb_ledpanel_fill_ctrl;
  localparam int FB = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [23:0] cmd_rgb = '0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [4:0]  host_x = '0, host_y = '0;
  logic [23:0] host_rgb = '0;
  logic        abort_in = 1'b0;
  logic        wr_enable;
  logic [4:0]  wr_addr_x, wr_addr_y;
  logic [23:0] wr_rgb_data;
  logic        busy, fill_done;

  always #5 clk = ~clk;

  ledpanel_fill_ctrl #(.FILL_BURST(FB)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_rgb(cmd_rgb),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_x(host_x), .host_y(host_y), .host_rgb(host_rgb),
`ifdef LEDPANEL_FILL_ABORT_EN
    .fill_abort(abort_in),
`endif
    .wr_enable(wr_enable), .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y),
    .wr_rgb_data(wr_rgb_data), .busy(busy), .fill_done(fill_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a fill is just the list of pixels still owed; the host gets a slot
  // whenever no fill is active or FB fill writes have gone out since its last grant.
  logic [9:0]  m_pix[$];
  bit          m_active = 0;
  int          m_run = 0;
  logic [23:0] m_rgb = '0;
  logic [4:0]  m_lx = '0, m_ly = '0;
  logic [23:0] m_lrgb = '0;

  int          obs_we = 0, obs_done = 0, obs_col = 0;
  logic [23:0] cnt_rgb = '0;
  logic [9:0]  obs_seq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          act0, hg, fg, acc, e_we, e_done;
    logic [9:0]  pxy;
    int          xa, xb, ya, yb;
    act0   = m_active;
    hg     = host_valid && (!m_active || m_run == FB);
    fg     = m_active && !hg && !abort_in;
    e_we   = 0;
    e_done = 0;
    if (hg) begin
      e_we = 1; m_lx = host_x; m_ly = host_y; m_lrgb = host_rgb;
    end else if (fg) begin
      pxy = m_pix.pop_front();
      e_we = 1; m_lx = pxy[9:5]; m_ly = pxy[4:0]; m_lrgb = m_rgb;
      e_done = (m_pix.size() == 0);
    end
    if (hg) m_run = 0;
    else if (fg && m_run < FB) m_run++;
    if (fg && m_pix.size() == 0) m_active = 0;
    if (m_active && abort_in) begin
      m_active = 0;
      m_pix.delete();
    end
    acc = cmd_valid && !act0;
    if (acc) begin
      xa = (cmd_x0 < cmd_x1) ? int'(cmd_x0) : int'(cmd_x1);
      xb = (cmd_x0 < cmd_x1) ? int'(cmd_x1) : int'(cmd_x0);
      ya = (cmd_y0 < cmd_y1) ? int'(cmd_y0) : int'(cmd_y1);
      yb = (cmd_y0 < cmd_y1) ? int'(cmd_y1) : int'(cmd_y0);
      for (int y = ya; y <= yb; y++)
        for (int x = xa; x <= xb; x++)
          m_pix.push_back({5'(x), 5'(y)});
      m_active = 1;
      m_run    = 0;
      m_rgb    = cmd_rgb;
    end
    @(posedge clk);
    #1;
    chk("wr_enable",  32'(wr_enable),   32'(e_we));
    chk("wr_addr_x",  32'(wr_addr_x),   32'(m_lx));
    chk("wr_addr_y",  32'(wr_addr_y),   32'(m_ly));
    chk("wr_rgb",     32'(wr_rgb_data), 32'(m_lrgb));
    chk("fill_done",  32'(fill_done),   32'(e_done));
    chk("busy",       32'(busy),        32'(m_active));
    chk("cmd_ready",  32'(cmd_ready),   32'(!m_active));
    chk("host_ready", 32'(host_ready),  32'(!m_active || m_run == FB));
    if (wr_enable) begin
      obs_we++;
      obs_seq.push_back({wr_addr_x, wr_addr_y});
      if (wr_rgb_data == cnt_rgb) obs_col++;
    end
    if (fill_done) obs_done++;
    if (acc) cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 0; host_valid = 0; abort_in = 0;
    resetn = 1'b0;
    #1;
    chk("rst_wr_enable",  32'(wr_enable),   0);
    chk("rst_busy",       32'(busy),        0);
    chk("rst_fill_done",  32'(fill_done),   0);
    chk("rst_cmd_ready",  32'(cmd_ready),   0);
    chk("rst_host_ready", 32'(host_ready),  0);
    chk("rst_wr_addr",    32'({wr_addr_x, wr_addr_y}), 0);
    chk("rst_wr_rgb",     32'(wr_rgb_data), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    m_pix.delete();
    m_active = 0; m_run = 0; m_lx = '0; m_ly = '0; m_lrgb = '0;
    step();
  endtask

  task automatic clear_obs();
    obs_we = 0; obs_done = 0; obs_col = 0;
    obs_seq.delete();
  endtask

  // host_mode: 0 idle, 1 held valid with fixed data, 2 random
  task automatic run_fill(input logic [4:0] x0, input logic [4:0] y0, input logic [4:0] x1,
                          input logic [4:0] y1, input logic [23:0] rgb, input int host_mode);
    int budget;
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_rgb = rgb;
    cmd_valid = 1'b1;
    budget = 3000;
    while ((cmd_valid || m_active) && budget > 0) begin
      if (host_mode == 2) begin
        host_valid = 1'($urandom);
        host_x = 5'($urandom); host_y = 5'($urandom); host_rgb = 24'($urandom);
      end else begin
        host_valid = (host_mode == 1);
      end
      step();
      budget--;
    end
    chk("fill_budget", 32'(m_active), 0);
    host_valid = 1'b0;
    step();
  endtask

  logic [9:0] ref_seq[$];

  initial begin
    do_reset();
    step();

    // Host write while idle
    clear_obs();
    host_valid = 1; host_x = 5'd3; host_y = 5'd5; host_rgb = 24'h123456;
    step();
    chk("host_idle_x", 32'(wr_addr_x), 3);
    chk("host_idle_y", 32'(wr_addr_y), 5);
    chk("host_idle_rgb", 32'(wr_rgb_data), 32'h123456);
    host_valid = 0;
    step(); step();
    chk("host_idle_count", 32'(obs_we), 1);

    // Small fill, then reversed corners
    clear_obs();
    run_fill(5'd2, 5'd1, 5'd4, 5'd2, 24'hFF0000, 0);
    chk("fill6_count", 32'(obs_we), 6);
    chk("fill6_done", 32'(obs_done), 1);
    ref_seq = obs_seq;
    clear_obs();
    run_fill(5'd4, 5'd2, 5'd2, 5'd1, 24'hFF0000, 0);
    chk("rev_count", 32'(obs_we), 6);
    for (int i = 0; i < 6 && i < obs_seq.size(); i++)
      chk("rev_seq", 32'(obs_seq[i]), 32'(ref_seq[i]));

    // Single pixel
    clear_obs();
    run_fill(5'd31, 5'd31, 5'd31, 5'd31, 24'h0000FF, 0);
    chk("single_count", 32'(obs_we), 1);

    // Full screen with host continuously requesting
    clear_obs();
    cnt_rgb = 24'hABCDEF;
    host_x = 5'd7; host_y = 5'd9; host_rgb = 24'h00FF00;
    run_fill(5'd0, 5'd0, 5'd31, 5'd31, 24'hABCDEF, 1);
    chk("full_fill_writes", 32'(obs_col), 1024);
    chk("full_fill_done", 32'(obs_done), 1);

    // Reset in the middle of a fill
    clear_obs();
    cnt_rgb = 24'h445566;
    cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 7; cmd_y1 = 3; cmd_rgb = 24'h445566;
    cmd_valid = 1;
    for (int i = 0; i < 40 && obs_col < 10; i++) step();
    chk("pre_reset_writes", 32'(obs_col), 10);
    do_reset();
    clear_obs();
    for (int i = 0; i < 6; i++) step();
    chk("post_reset_writes", 32'(obs_we), 0);

`ifdef LEDPANEL_FILL_ABORT_EN
    clear_obs();
    cnt_rgb = 24'h778899;
    cmd_x0 = 0; cmd_y0 = 4; cmd_x1 = 31; cmd_y1 = 4; cmd_rgb = 24'h778899;
    cmd_valid = 1;
    for (int i = 0; i < 40 && obs_col < 5; i++) step();
    abort_in = 1;
    step();
    abort_in = 0;
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 5; i++) step();
    chk("abort_writes", 32'(obs_col), 5);
    chk("abort_done", 32'(obs_done), 0);
`endif

    // Randomized traffic: overlapping commands, host requests, back-to-back fills
    cnt_rgb = 24'h000000;
    for (int i = 0; i < 1500; i++) begin
      if (!cmd_valid && $urandom_range(0, 5) == 0) begin
        cmd_x0 = 5'($urandom); cmd_y0 = 5'($urandom);
        cmd_x1 = cmd_x0 ^ 5'($urandom_range(0, 7));
        cmd_y1 = cmd_y0 ^ 5'($urandom_range(0, 3));
        cmd_rgb = 24'($urandom);
        cmd_valid = 1;
      end
      host_valid = ($urandom_range(0, 2) == 0);
      host_x = 5'($urandom); host_y = 5'($urandom); host_rgb = 24'($urandom);
`ifdef LEDPANEL_FILL_ABORT_EN
      abort_in = ($urandom_range(0, 40) == 0);
`endif
      step();
    end
    abort_in = 0;
    host_valid = 0;
    for (int i = 0; i < 3000 && (cmd_valid || m_active); i++) step();
    chk("drain_idle", 32'(m_active || cmd_valid), 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
